// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared types, defaults and round-robin pick helper for mult_share_arb
package mult_arb_pkg;

    localparam int WIDTH_D   = 8;
    localparam int N_REQ_D   = 4;
    localparam int MUL_LAT_D = 2;

    // Helper widths sized for the largest supported requester count (8).
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    // One tag pipe entry: valid bit plus the requester index it belongs to.
    typedef struct packed {
        logic                v;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // First set bit of valid at or after ptr, wrapping at n lanes.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int                  n
    );
        pick_t r;
        int    idx;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !r.found && valid[idx[MAX_ID_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[MAX_ID_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - pointer-based round-robin arbiter with combinational grant
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_D,
    parameter int ID_W  = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [N_REQ-1:0] valid,
    output logic [N_REQ-1:0] ready,
    output logic [ID_W-1:0]  grant,
    output logic             transfer
);

    logic [ID_W-1:0]     ptr;
    logic [MAX_REQ-1:0]  valid_ext;
    logic [MAX_ID_W-1:0] ptr_ext;
    pick_t               pick;
    logic                unused_pick;

    assign unused_pick = &{1'b0, pick};

    // Search from the pointer; ready is one-hot on the granted lane only when enabled.
    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = valid;
        ptr_ext                = '0;
        ptr_ext[ID_W-1:0]      = ptr;
        pick                   = rr_pick(valid_ext, ptr_ext, N_REQ);
        grant                  = pick.idx[ID_W-1:0];
        transfer               = en & pick.found;
        ready                  = '0;
        if (transfer) begin
            ready[grant] = 1'b1;
        end
    end

    // Pointer moves just past the granted lane on a transfer, otherwise holds.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr <= '0;
        end else if (transfer) begin
            if (grant == ID_W'(N_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - shares one pipelined multiplier among N_REQ requesters
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int WIDTH   = WIDTH_D,
    parameter int N_REQ   = N_REQ_D,
    parameter int MUL_LAT = MUL_LAT_D,
    parameter int ID_W    = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_mx,
    input  logic [N_REQ*WIDTH-1:0] req_my,
    output logic [WIDTH-1:0]       mul_mx,
    output logic [WIDTH-1:0]       mul_my,
    input  logic [2*WIDTH-1:0]     mul_product,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_product,
    output logic [ID_W+1:0]        inflight,
    output logic                   idle
);

    logic [ID_W-1:0]     grant;
    logic                transfer;
    logic [MAX_ID_W-1:0] grant_ext;
    logic [WIDTH-1:0]    lane_mx [N_REQ];
    logic [WIDTH-1:0]    lane_my [N_REQ];
    tag_t                pipe [MUL_LAT+1];
    tag_t                tail;
    logic                unused_tail;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .CLK      (CLK),
        .RST      (RST),
        .en       (en),
        .valid    (req_valid),
        .ready    (req_ready),
        .grant    (grant),
        .transfer (transfer)
    );

    assign tail        = pipe[MUL_LAT];
    assign unused_tail = &{1'b0, tail};
    assign idle        = (inflight == '0) && !(|req_ready);

    // Unpack lane operands and widen the grant index into the tag format.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lane_mx[i] = req_mx[i*WIDTH +: WIDTH];
            lane_my[i] = req_my[i*WIDTH +: WIDTH];
        end
        grant_ext            = '0;
        grant_ext[ID_W-1:0]  = grant;
    end

    // Operand registers load only on a transfer; held values produce ignored products.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mul_mx <= '0;
            mul_my <= '0;
        end else if (transfer) begin
            mul_mx <= lane_mx[grant];
            mul_my <= lane_my[grant];
        end
    end

    // Tag pipe mirrors the multiplier latency so the tail lines up with mul_product.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i <= MUL_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{v: transfer, id: grant_ext};
            for (int i = 1; i <= MUL_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Capture the product and route it back as a single-cycle one-hot valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp_valid   <= '0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            rsp_valid <= '0;
            if (tail.v) begin
                rsp_product <= mul_product;
                rsp_id      <= tail.id[ID_W-1:0];
                rsp_valid   <= N_REQ'(1) << tail.id[ID_W-1:0];
            end
        end
    end

    // Count accepted ops not yet answered; accept and respond together cancel out.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            inflight <= '0;
        end else begin
            case ({transfer, tail.v})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - scoreboard bench for mult_share_arb with a behavioural multiplier
module tb_mult_share_arb;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int LAT   = 2;
    localparam int ID_W  = 2;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic                 en  = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N*WIDTH-1:0]   req_mx = '0;
    logic [N*WIDTH-1:0]   req_my = '0;
    logic [WIDTH-1:0]     mul_mx;
    logic [WIDTH-1:0]     mul_my;
    logic [2*WIDTH-1:0]   mul_product = '0;
    logic [2*WIDTH-1:0]   p1 = '0;
    logic [N-1:0]         rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [2*WIDTH-1:0]   rsp_product;
    logic [ID_W+1:0]      inflight;
    logic                 idle;

    mult_share_arb #(
        .WIDTH   (WIDTH),
        .N_REQ   (N),
        .MUL_LAT (LAT),
        .ID_W    (ID_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .en          (en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mx      (req_mx),
        .req_my      (req_my),
        .mul_mx      (mul_mx),
        .mul_my      (mul_my),
        .mul_product (mul_product),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .inflight    (inflight),
        .idle        (idle)
    );

    always #5 CLK = ~CLK;

    // Signed two-stage multiplier: product appears LAT edges after an operand change.
    always @(posedge CLK) begin
        p1          <= $signed(mul_mx) * $signed(mul_my);
        mul_product <= p1;
    end

    typedef struct {
        int                 id;
        logic [2*WIDTH-1:0] prod;
        int                 cyc;
    } exp_t;

    exp_t               q[$];
    int                 glog[$];
    int                 rid_log[$];
    logic [2*WIDTH-1:0] rprod_log[$];
    int                 total = 0;
    int                 bad   = 0;
    int                 mptr  = 0;
    int                 cyc   = 0;
    int                 maxinf = 0;
    bit                 chk_mx = 1'b0;
    logic [WIDTH-1:0]   last_mx, last_my;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops responses, checks grants against the round-robin model, pushes expectations.
    always @(negedge CLK) begin
        if (!RST) begin
            q.delete();
            mptr   = 0;
            chk_mx = 1'b0;
        end else begin
            exp_t                e;
            int                  g;
            int                  lane;
            int                  pr;
            logic [N-1:0]        er;
            logic signed [WIDTH-1:0] a, b;
            if (chk_mx) begin
                check("mul_mx", 64'(mul_mx), 64'(last_mx));
                check("mul_my", 64'(mul_my), 64'(last_my));
            end
            chk_mx = 1'b0;
            if (rsp_valid != '0) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'(1 << e.id));
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_product", 64'(rsp_product), 64'(e.prod));
                    // Pushed on the negedge before the accept edge; visible LAT+1 edges later.
                    check("rsp_latency", 64'(cyc - e.cyc), 64'(LAT + 2));
                    rid_log.push_back(int'(rsp_id));
                    rprod_log.push_back(rsp_product);
                end
            end
            check("inflight", 64'(inflight), 64'(q.size()));
            if (int'(inflight) > maxinf) maxinf = int'(inflight);
            g = -1;
            if (en) begin
                for (int k = 0; k < N; k++) begin
                    lane = (mptr + k) % N;
                    if (g < 0 && ((req_valid >> lane) & 1) != 0) g = lane;
                end
            end
            er = (g >= 0) ? N'(1 << g) : '0;
            check("req_ready", 64'(req_ready), 64'(er));
            check("idle", 64'(idle), 64'(q.size() == 0 && g < 0));
            if (g >= 0) begin
                a = WIDTH'(req_mx >> (g * WIDTH));
                b = WIDTH'(req_my >> (g * WIDTH));
                pr = int'(a) * int'(b);
                e.id = g;
                e.prod = (2*WIDTH)'(pr);
                e.cyc = cyc;
                q.push_back(e);
                glog.push_back(g);
                mptr = (g + 1) % N;
                last_mx = a;
                last_my = b;
                chk_mx = 1'b1;
            end
            cyc++;
        end
    end

    task automatic step(input int n, input bit rnd);
        repeat (n) begin
            @(posedge CLK);
            #1;
            if (rnd) begin
                req_mx = $urandom;
                req_my = $urandom;
            end
        end
    endtask

    task automatic summary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: run did not complete in time");
        summary();
    end

    initial begin
        int base;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_mul_mx", 64'(mul_mx), 64'(0));
        check("reset_mul_my", 64'(mul_my), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_id", 64'(rsp_id), 64'(0));
        check("reset_rsp_product", 64'(rsp_product), 64'(0));
        check("reset_inflight", 64'(inflight), 64'(0));
        check("reset_idle", 64'(idle), 64'(1));
        RST = 1'b1;

        // All lanes valid from ptr=0.
        step(1, 1'b0);
        glog.delete();
        en = 1'b1;
        req_valid = 4'hF;
        req_mx = $urandom;
        req_my = $urandom;
        step(8, 1'b1);
        req_valid = '0;
        step(6, 1'b0);
        check("all_grant_count", 64'(glog.size()), 64'(8));
        if (glog.size() >= 5) begin
            check("all_g0", 64'(glog[0]), 64'(0));
            check("all_g1", 64'(glog[1]), 64'(1));
            check("all_g2", 64'(glog[2]), 64'(2));
            check("all_g3", 64'(glog[3]), 64'(3));
            check("all_g4", 64'(glog[4]), 64'(0));
        end
        check("inflight_peak", 64'(maxinf), 64'(LAT + 1));

        // Single lane 1: 7*5.
        rid_log.delete();
        rprod_log.delete();
        req_mx = 32'h0000_0700;
        req_my = 32'h0000_0500;
        req_valid = 4'b0010;
        step(1, 1'b0);
        req_valid = '0;
        step(6, 1'b0);
        check("single_count", 64'(rid_log.size()), 64'(1));
        if (rid_log.size() == 1) begin
            check("single_id", 64'(rid_log[0]), 64'(1));
            check("single_prod", 64'(rprod_log[0]), 64'(16'h0023));
        end

        // Lane 0 alone moves ptr to 1, then lanes 0 and 2 compete.
        req_valid = 4'b0001;
        step(1, 1'b0);
        req_valid = '0;
        step(5, 1'b0);
        glog.delete();
        req_valid = 4'b0101;
        step(3, 1'b1);
        req_valid = '0;
        step(6, 1'b0);
        check("fair_count", 64'(glog.size()), 64'(3));
        if (glog.size() == 3) begin
            check("fair_g0", 64'(glog[0]), 64'(2));
            check("fair_g1", 64'(glog[1]), 64'(0));
            check("fair_g2", 64'(glog[2]), 64'(2));
        end

        // en toggle with two ops in flight: grants 3,0 then pause; resume at lane 1.
        rid_log.delete();
        req_valid = 4'hF;
        step(2, 1'b1);
        en = 1'b0;
        step(6, 1'b1);
        check("en_drain_count", 64'(rid_log.size()), 64'(2));
        check("en_idle", 64'(idle), 64'(1));
        glog.delete();
        en = 1'b1;
        step(1, 1'b0);
        req_valid = '0;
        step(6, 1'b0);
        check("en_resume_count", 64'(glog.size()), 64'(1));
        if (glog.size() >= 1) check("en_resume_lane", 64'(glog[0]), 64'(1));

        // Boundary operands through lane 3.
        rid_log.delete();
        rprod_log.delete();
        req_valid = 4'b1000;
        req_mx = 32'hFF00_0000;
        req_my = 32'hFF00_0000;
        step(1, 1'b0);
        req_mx = 32'h8000_0000;
        req_my = 32'h7F00_0000;
        step(1, 1'b0);
        req_valid = '0;
        step(6, 1'b0);
        check("bnd_count", 64'(rid_log.size()), 64'(2));
        if (rid_log.size() == 2) begin
            check("bnd_id0", 64'(rid_log[0]), 64'(3));
            check("bnd_prod0", 64'(rprod_log[0]), 64'(16'h0001));
            check("bnd_id1", 64'(rid_log[1]), 64'(3));
            check("bnd_prod1", 64'(rprod_log[1]), 64'(16'hC080));
        end

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            en = ($urandom % 8) != 0;
            req_valid = N'($urandom);
            step(1, 1'b1);
        end
        en = 1'b1;
        req_valid = '0;
        step(8, 1'b0);
        check("rand_idle", 64'(idle), 64'(1));

        // Reset mid-stream: three ops on lane 0, reset in the cycle after the 2nd accept.
        rid_log.delete();
        base = cyc;
        req_valid = 4'b0001;
        req_mx = $urandom;
        req_my = $urandom;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("mid_rst_mul_mx", 64'(mul_mx), 64'(0));
        check("mid_rst_mul_my", 64'(mul_my), 64'(0));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
        check("mid_rst_rsp_product", 64'(rsp_product), 64'(0));
        check("mid_rst_inflight", 64'(inflight), 64'(0));
        check("mid_rst_accepts", 64'(cyc - base), 64'(2));
        req_valid = '0;
        step(2, 1'b0);
        RST = 1'b1;
        step(8, 1'b0);
        check("mid_rst_no_rsp", 64'(rid_log.size()), 64'(0));
        check("mid_rst_inflight_after", 64'(inflight), 64'(0));

        summary();
    end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one pipelined radix-8 Booth multiplier among N_REQ requesters.
- Round-robin arbitration: grants at most one request per cycle and drives the multiplier operand inputs from a register.
- Tracks in-flight operations with a tag shift register and routes each product back to its requester with a one-hot valid.
- Sits between requester lanes (e.g. MAC/PE units) and a single mb8_top-class multiplier instance.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH.
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 2, CLK edges from a change on mul_mx/mul_my to the matching mul_product.
- ID_W, 2, requester index width; must equal clog2(N_REQ).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- en  in  1  grant enable; when low, no new grants, in-flight ops drain.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept, combinational, at most one bit high.
- req_mx  in  N_REQ*WIDTH  packed multiplicands; lane i at [i*WIDTH +: WIDTH].
- req_my  in  N_REQ*WIDTH  packed multipliers, same packing.
- mul_mx  out  WIDTH  registered operand to multiplier.
- mul_my  out  WIDTH  registered operand to multiplier.
- mul_product  in  2*WIDTH  multiplier result.
- rsp_valid  out  N_REQ  one-hot result valid, registered, single cycle.
- rsp_id  out  ID_W  index of the responding requester.
- rsp_product  out  2*WIDTH  registered product.
- inflight  out  ID_W+2  number of accepted ops not yet responded.
- idle  out  1  high when inflight==0 and no req_ready is high.

Behaviour:
- Reset (RST=0, async):
  - mul_mx=0, mul_my=0, rsp_valid=0, rsp_id=0, rsp_product=0, inflight=0.
  - Round-robin pointer=0; tag pipe cleared.
  - In-flight ops at reset are discarded; no response is ever produced for them.
- Arbitration (combinational, each cycle):
  - If en=1 and any req_valid is set, grant the first set req_valid at or after ptr, searching cyclically: ptr, ptr+1, ..., N_REQ-1, 0, ...
  - req_ready[g]=1 for the granted index g only. The grant is independent of req_ready history, so there is no valid-depends-on-ready loop.
  - Transfer happens when req_valid[g] && req_ready[g] at a rising edge.
  - On transfer: ptr <= (g+1) mod N_REQ. With no transfer, ptr holds.
- Issue: on transfer edge k, mul_mx/mul_my <= lane g operands. Otherwise they hold their last value; the multiplier output for held operands is ignored.
- Tag pipe:
  - Depth MUL_LAT+1; each entry is {v, id}.
  - Stage 0 <= {transfer, g} at every edge; the pipe shifts every edge.
- Response timing:
  - When the final stage of the tag pipe is valid, at edge k+MUL_LAT+1:
    - rsp_product <= mul_product
    - rsp_id <= id
    - rsp_valid <= one-hot(id)
  - Otherwise rsp_valid <= 0, and rsp_product/rsp_id hold.
  - Total latency from request accept to rsp_valid is MUL_LAT+1 cycles.
  - Throughput is one op per cycle; responses return in issue order.
  - Responses have no backpressure; requesters must always sink them.
- inflight accounting:
  - +1 on transfer, -1 when a response is produced; both in the same cycle leaves it unchanged.
  - The maximum value is MUL_LAT+1 and must never be exceeded.
- en deasserted: req_ready=0 for all lanes next combinational evaluation; ptr holds; pipe drains normally; idle rises after the last response.
- Single requester: the same lane is granted on consecutive cycles back-to-back.
- Signedness: operands and product are passed through untouched; the multiplier's signedness applies.

Decomposition:
- Shared package mult_arb_pkg:
  - tag struct {logic v; logic [ID_W-1:0] id}
  - default WIDTH/N_REQ/MUL_LAT constants
  - function rr_pick(valid, ptr) returning grant index and found flag
- One natural sub-module: rr_arbiter (N_REQ-wide, pointer-based, combinational grant plus registered pointer). The tag pipe and response logic stay in the top.

Test Plan:
- Reset mid-stream:
  - Stimulus: issue 3 ops, assert RST=0 on the cycle after the 2nd accept.
  - Required: all outputs 0 immediately; no rsp_valid for any issued op after release; inflight=0.
- Single lane:
  - Stimulus: lane 1 sends 0x07*0x05.
  - Required: mul_mx=0x07 one cycle after accept; rsp_valid=4'b0010, rsp_id=1, rsp_product=0x0023 exactly MUL_LAT+1 cycles after accept.
- All four lanes valid continuously from ptr=0:
  - Required: grants 0,1,2,3,0 on consecutive cycles.
  - Required: responses in the same order, one per cycle; inflight saturates at 3 with MUL_LAT=2.
- Fairness skip:
  - Stimulus: only lanes 0 and 2 valid, ptr=1.
  - Required: grant 2 then 0 then 2; lane 2 is never starved.
- en toggle:
  - Stimulus: en=0 while lanes valid and 2 ops in flight.
  - Required: no req_ready; 2 responses still emerge; idle=1 afterward; on en=1 the grant resumes at the stored ptr.
- Signed/boundary operands:
  - Stimulus: 0xFF*0xFF and 0x80*0x7F through lane 3.
  - Required: rsp_product equals the multiplier's direct output for the same operands (golden model), correct lane routing.
